tx_link_scheduler: RTL and testbench

- Link-layer-facing scheduler that feeds the multi-lane TX datapath one byte per cycle.
- Arbitrates between TLP and DLLP byte streams and wraps each packet in 8b10b framing K-symbols (STP/SDP … END).
- Inserts periodic SKP ordered sets and emits logical idle when there is no traffic.
- Drives the per-byte control the lane datapath needs: valid, K-symbol flag, ordered-set flag, scrambler bypass.

---
 rtl/pcie_phy_pkg.sv | 43 ++++
 rtl/skp_interval_timer.sv | 50 +++++
 rtl/tx_link_scheduler.sv | 169 ++++++++++++++++
 tb/tb_tx_link_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared 8b10b K-code constants, scheduler state encoding and the per-byte
// control bundle handed to the lane datapath.
package pcie_phy_pkg;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SKP_COM,
        ST_SKP_SYM,
        ST_TLP_STP,
        ST_TLP_BODY,
        ST_TLP_END,
        ST_DLLP_SDP,
        ST_DLLP_BODY,
        ST_DLLP_END
    } tx_sched_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       k;
        logic       os;
        logic       bypass;
    } tx_symbol_t;

    // Builds a valid byte with its lane-control flags.
    function automatic tx_symbol_t make_sym(input logic [7:0] data, input logic k,
                                           input logic os, input logic bypass);
        tx_symbol_t s;
        s.data   = data;
        s.valid  = 1'b1;
        s.k      = k;
        s.os     = os;
        s.bypass = bypass;
        return s;
    endfunction

endpackage

// File: rtl/skp_interval_timer.sv
// Free-running SKP interval counter with a sticky request flag; a second
// expiry while a request is still waiting does not queue another one.
module skp_interval_timer #(
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic pending_o
);

    localparam int unsigned CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             expire;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        expire    = (count_q == CNT_W'(SKP_INTERVAL - 1));
        count_d   = expire ? '0 : count_q + CNT_W'(1);
        pending_d = pending_q;
        if (expire) begin
            pending_d = 1'b1;
        end
        // Consuming the request wins over a coincident expiry.
        if (clear_i) begin
            pending_d = 1'b0;
        end
        if (!enable_i) begin
            count_d   = '0;
            pending_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/tx_link_scheduler.sv
// Byte-per-cycle TX scheduler: arbitrates TLP/DLLP streams, frames them with
// STP/SDP..END, inserts SKP ordered sets and fills gaps with logical idle.
module tx_link_scheduler
    import pcie_phy_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL    = 1180,
    parameter int unsigned SKP_COUNT       = 3,
    parameter int unsigned DLLP_STREAK_MAX = 4,
    parameter int unsigned DATA_WIDTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  link_up_i,
    input  logic [DATA_WIDTH-1:0] tlp_data_i,
    input  logic                  tlp_valid_i,
    input  logic                  tlp_last_i,
    output logic                  tlp_ready_o,
    input  logic [DATA_WIDTH-1:0] dllp_data_i,
    input  logic                  dllp_valid_i,
    input  logic                  dllp_last_i,
    output logic                  dllp_ready_o,
    output logic [DATA_WIDTH-1:0] data_frame_o,
    output logic                  data_frame_valid_o,
    output logic                  is_k_symbol_o,
    output logic                  is_ordered_set_o,
    output logic                  bypass_scrambler_o,
    output logic                  skp_pending_o
);

    localparam int unsigned STREAK_W = (DLLP_STREAK_MAX > 0) ? $clog2(DLLP_STREAK_MAX + 1) : 1;

    tx_sched_state_e     state_q, state_d;
    logic [2:0]          skp_cnt_q, skp_cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    tx_symbol_t          out_q, out_d;
    logic                skp_pending;
    logic                skp_grant;
    logic                arb;

    skp_interval_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (link_up_i),
        .clear_i  (skp_grant),
        .pending_o(skp_pending)
    );

    assign tlp_ready_o  = link_up_i && !rst_i && (state_q == ST_TLP_BODY);
    assign dllp_ready_o = link_up_i && !rst_i && (state_q == ST_DLLP_BODY);

    always_comb begin
        state_d   = state_q;
        skp_cnt_d = skp_cnt_q;
        streak_d  = streak_q;
        out_d     = '0;
        skp_grant = 1'b0;
        arb       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_d = make_sym(8'h00, 1'b0, 1'b0, 1'b0);
                arb   = 1'b1;
            end
            ST_SKP_COM: begin
                out_d     = make_sym(K_COM, 1'b1, 1'b1, 1'b1);
                skp_cnt_d = '0;
                state_d   = ST_SKP_SYM;
            end
            ST_SKP_SYM: begin
                out_d = make_sym(K_SKP, 1'b1, 1'b1, 1'b1);
                if (skp_cnt_q == 3'(SKP_COUNT - 1)) begin
                    arb = 1'b1;
                end else begin
                    skp_cnt_d = skp_cnt_q + 3'd1;
                end
            end
            ST_TLP_STP: begin
                out_d   = make_sym(K_STP, 1'b1, 1'b0, 1'b1);
                state_d = ST_TLP_BODY;
            end
            ST_TLP_BODY: begin
                // A missing byte leaves out_d at zero: a bubble with valid low.
                if (tlp_valid_i) begin
                    out_d = make_sym(tlp_data_i, 1'b0, 1'b0, 1'b0);
                    if (tlp_last_i) begin
                        state_d = ST_TLP_END;
                    end
                end
            end
            ST_TLP_END: begin
                out_d = make_sym(K_END, 1'b1, 1'b0, 1'b1);
                arb   = 1'b1;
            end
            ST_DLLP_SDP: begin
                out_d   = make_sym(K_SDP, 1'b1, 1'b0, 1'b1);
                state_d = ST_DLLP_BODY;
            end
            ST_DLLP_BODY: begin
                if (dllp_valid_i) begin
                    out_d = make_sym(dllp_data_i, 1'b0, 1'b0, 1'b0);
                    if (dllp_last_i) begin
                        state_d = ST_DLLP_END;
                    end
                end
            end
            ST_DLLP_END: begin
                out_d = make_sym(K_END, 1'b1, 1'b0, 1'b1);
                arb   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Packet boundaries choose the next byte directly, so frames run back to back.
        if (arb) begin
            if (skp_pending) begin
                state_d   = ST_SKP_COM;
                skp_grant = 1'b1;
            end else if (tlp_valid_i && (streak_q == STREAK_W'(DLLP_STREAK_MAX))) begin
                state_d  = ST_TLP_STP;
                streak_d = '0;
            end else if (dllp_valid_i) begin
                state_d = ST_DLLP_SDP;
                if (streak_q != STREAK_W'(DLLP_STREAK_MAX)) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end else if (tlp_valid_i) begin
                state_d  = ST_TLP_STP;
                streak_d = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // Losing the link abandons any packet in flight without an END.
        if (!link_up_i) begin
            state_d   = ST_IDLE;
            out_d     = '0;
            streak_d  = '0;
            skp_cnt_d = '0;
            skp_grant = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            skp_cnt_q <= '0;
            streak_q  <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            skp_cnt_q <= skp_cnt_d;
            streak_q  <= streak_d;
            out_q     <= out_d;
        end
    end

    assign data_frame_o       = out_q.data;
    assign data_frame_valid_o = out_q.valid;
    assign is_k_symbol_o      = out_q.k;
    assign is_ordered_set_o   = out_q.os;
    assign bypass_scrambler_o = out_q.bypass;
    assign skp_pending_o      = skp_pending;

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Bench for tx_link_scheduler: fixed TLP vector table, SKP cadence and link-drop
// sequences, then random traffic against a queue-based reference model.
module tb_tx_link_scheduler;

    localparam int INTV = 16;
    localparam int NSKP = 3;
    localparam int SMAX = 2;

    logic       clk = 1'b0;
    logic       rst, link_up;
    logic [7:0] tlp_data, dllp_data;
    logic       tlp_valid, tlp_last, tlp_ready;
    logic       dllp_valid, dllp_last, dllp_ready;
    logic [7:0] data_frame;
    logic       frame_valid, is_k, is_os, bypass, skp_pending;

    tx_link_scheduler #(
        .SKP_INTERVAL   (INTV),
        .SKP_COUNT      (NSKP),
        .DLLP_STREAK_MAX(SMAX),
        .DATA_WIDTH     (8)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .link_up_i         (link_up),
        .tlp_data_i        (tlp_data),
        .tlp_valid_i       (tlp_valid),
        .tlp_last_i        (tlp_last),
        .tlp_ready_o       (tlp_ready),
        .dllp_data_i       (dllp_data),
        .dllp_valid_i      (dllp_valid),
        .dllp_last_i       (dllp_last),
        .dllp_ready_o      (dllp_ready),
        .data_frame_o      (data_frame),
        .data_frame_valid_o(frame_valid),
        .is_k_symbol_o     (is_k),
        .is_ordered_set_o  (is_os),
        .bypass_scrambler_o(bypass),
        .skp_pending_o     (skp_pending)
    );

    always #5 clk = ~clk;

    logic [11:0] obs;
    assign obs = {data_frame, frame_valid, is_k, is_os, bypass};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {data, valid, k, os, bypass}
    function automatic logic [11:0] sym(input logic [7:0] d, input bit v, input bit k,
                                        input bit os, input bit bp);
        return {d, v, k, os, bp};
    endfunction

    task automatic sources_idle();
        tlp_valid  = 1'b0; tlp_data  = 8'h00; tlp_last  = 1'b0;
        dllp_valid = 1'b0; dllp_data = 8'h00; dllp_last = 1'b0;
    endtask

    // Leaves the bench at a falling edge, reset still asserted over the previous rising edges.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; link_up = 1'b0; sources_idle();
        repeat (2) @(negedge clk);
    endtask

    // Reference model: a queue of symbols still to be emitted; arbitration refills it.
    typedef struct {
        logic [11:0] s;
        int          kind;   // 0 fixed symbol, 1 TLP body, 2 DLLP body
    } item_t;

    item_t m_q[$];
    int    m_timer, m_pend, m_streak;

    function automatic item_t fixed(input logic [11:0] s);
        item_t it;
        it.s = s; it.kind = 0;
        return it;
    endfunction

    function automatic item_t body(input int kind);
        item_t it;
        it.s = '0; it.kind = kind;
        return it;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_q.push_back(fixed(sym(8'h00, 1, 0, 0, 0)));
        m_timer = 0; m_pend = 0; m_streak = 0;
    endtask

    task automatic model_step(input bit r, input bit lu,
                              input bit tv, input logic [7:0] td, input bit tl,
                              input bit dv, input logic [7:0] dd, input bit dl,
                              output bit tr, output bit dr, output logic [11:0] emit);
        item_t      it;
        bit         expire, took_skp, v, last;
        logic [7:0] d;
        tr = 1'b0; dr = 1'b0; emit = '0;
        if (r || !lu) begin
            model_reset();
            return;
        end
        it = m_q.pop_front();
        if (it.kind == 0) begin
            emit = it.s;
        end else begin
            tr   = (it.kind == 1);
            dr   = (it.kind == 2);
            v    = tr ? tv : dv;
            d    = tr ? td : dd;
            last = tr ? tl : dl;
            if (v) begin
                emit = sym(d, 1, 0, 0, 0);
                if (last) m_q.push_front(fixed(sym(8'hFD, 1, 1, 0, 1)));
                else      m_q.push_front(it);
            end else begin
                m_q.push_front(it);
            end
        end
        expire   = (m_timer == INTV - 1);
        m_timer  = expire ? 0 : m_timer + 1;
        took_skp = 1'b0;
        if (m_q.size() == 0) begin
            if (m_pend != 0) begin
                took_skp = 1'b1;
                m_q.push_back(fixed(sym(8'hBC, 1, 1, 1, 1)));
                for (int i = 0; i < NSKP; i++) m_q.push_back(fixed(sym(8'h1C, 1, 1, 1, 1)));
            end else if (tv && m_streak == SMAX) begin
                m_streak = 0;
                m_q.push_back(fixed(sym(8'hFB, 1, 1, 0, 1)));
                m_q.push_back(body(1));
            end else if (dv) begin
                if (m_streak < SMAX) m_streak++;
                m_q.push_back(fixed(sym(8'h5C, 1, 1, 0, 1)));
                m_q.push_back(body(2));
            end else if (tv) begin
                m_streak = 0;
                m_q.push_back(fixed(sym(8'hFB, 1, 1, 0, 1)));
                m_q.push_back(body(1));
            end else begin
                m_q.push_back(fixed(sym(8'h00, 1, 0, 0, 0)));
            end
        end
        if (took_skp)    m_pend = 0;
        else if (expire) m_pend = 1;
    endtask

    typedef struct {
        bit          lu;
        bit          tv;
        logic [7:0]  td;
        bit          tl;
        bit          exp_tr;
        logic [11:0] exp_obs;
    } vec_t;

    vec_t vecs[10];

    logic [8:0]  tq[$];
    logic [8:0]  dq[$];
    logic [11:0] exp_prev, emit;
    bit          exp_tr, exp_dr;
    int          down_left, rst_left;

    initial begin
        logic [11:0] e;
        vecs[0] = '{1, 1, 8'h11, 0, 0, 12'h000};
        vecs[1] = '{1, 1, 8'h11, 0, 0, sym(8'h00, 1, 0, 0, 0)};
        vecs[2] = '{1, 1, 8'h11, 0, 1, sym(8'hFB, 1, 1, 0, 1)};
        vecs[3] = '{1, 1, 8'h22, 0, 1, sym(8'h11, 1, 0, 0, 0)};
        vecs[4] = '{1, 0, 8'h00, 0, 1, sym(8'h22, 1, 0, 0, 0)};
        vecs[5] = '{1, 1, 8'h33, 0, 1, 12'h000};
        vecs[6] = '{1, 1, 8'h44, 1, 1, sym(8'h33, 1, 0, 0, 0)};
        vecs[7] = '{1, 0, 8'h00, 0, 0, sym(8'h44, 1, 0, 0, 0)};
        vecs[8] = '{1, 0, 8'h00, 0, 0, sym(8'hFD, 1, 1, 0, 1)};
        vecs[9] = '{1, 0, 8'h00, 0, 0, sym(8'h00, 1, 0, 0, 0)};

        rst = 1'b1; link_up = 1'b0; sources_idle();

        // Idle link: reset value, logical idle, then SKP ordered sets every INTV cycles.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            rst = 1'b0; link_up = 1'b1;
            if (c == 0)                                    e = 12'h000;
            else if (c >= 18 && ((c - 18) % INTV) == 0)    e = sym(8'hBC, 1, 1, 1, 1);
            else if (c >= 18 && ((c - 18) % INTV) <= NSKP) e = sym(8'h1C, 1, 1, 1, 1);
            else                                           e = sym(8'h00, 1, 0, 0, 0);
            check("skp_cadence", obs, e);
            check("skp_pending", skp_pending, (c >= 16 && ((c - 16) % INTV) == 0));
            @(negedge clk);
        end

        // TLP 11,22,<gap>,33,44 from the vector table.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rst = 1'b0;
            link_up = vecs[i].lu; tlp_valid = vecs[i].tv; tlp_data = vecs[i].td; tlp_last = vecs[i].tl;
            check("tlp_vec_out", obs, vecs[i].exp_obs);
            #1;
            check("tlp_vec_ready", tlp_ready, vecs[i].exp_tr);
            check("tlp_vec_dready", dllp_ready, 0);
            @(negedge clk);
        end

        // Link dropped mid-body, then relinked: SKP timer starts again from zero.
        do_reset();
        for (int c = 0; c < 7 + 20; c++) begin
            rst = 1'b0;
            link_up   = !(c >= 4 && c < 7);
            tlp_valid = (c < 7); tlp_data = 8'(c + 8'h40); tlp_last = 1'b0;
            if (c == 5 || c == 6 || c == 7) check("drop_zero", obs, 12'h000);
            if (c == 8)  check("relink_idle", obs, sym(8'h00, 1, 0, 0, 0));
            if (c == 24) check("relink_pre_skp", obs, sym(8'h00, 1, 0, 0, 0));
            if (c == 25) check("relink_skp_com", obs, sym(8'hBC, 1, 1, 1, 1));
            #1;
            if (c == 3) check("body_ready", tlp_ready, 1);
            if (c == 4) check("drop_ready", tlp_ready, 0);
            @(negedge clk);
        end

        // Random traffic with occasional link drops and resets against the model.
        do_reset();
        model_reset();
        tq.delete(); dq.delete();
        exp_prev = '0; down_left = 0; rst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            check("rand_out", obs, exp_prev);
            check("rand_pending", skp_pending, m_pend[0]);
            if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 2);
            if (down_left == 0 && $urandom_range(0, 249) == 0) down_left = $urandom_range(1, 5);
            rst     = (rst_left != 0);
            link_up = (down_left == 0) ? 1'b1 : 1'b0;
            if (rst_left != 0) rst_left--;
            if (down_left != 0) down_left--;

            if (tq.size() == 0 && $urandom_range(0, 5) == 0) begin
                int len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++) tq.push_back({(i == len - 1), 8'($urandom)});
            end
            if (dq.size() == 0 && $urandom_range(0, 2) == 0) begin
                int len = $urandom_range(2, 6);
                for (int i = 0; i < len; i++) dq.push_back({(i == len - 1), 8'($urandom)});
            end
            tlp_valid  = (tq.size() != 0) && ($urandom_range(0, 4) != 0);
            tlp_data   = tlp_valid ? tq[0][7:0] : 8'($urandom);
            tlp_last   = tlp_valid ? tq[0][8] : 1'b0;
            dllp_valid = (dq.size() != 0) && ($urandom_range(0, 7) != 0);
            dllp_data  = dllp_valid ? dq[0][7:0] : 8'($urandom);
            dllp_last  = dllp_valid ? dq[0][8] : 1'b0;
            #1;
            model_step(rst, link_up, tlp_valid, tlp_data, tlp_last,
                       dllp_valid, dllp_data, dllp_last, exp_tr, exp_dr, emit);
            check("rand_tready", tlp_ready, exp_tr);
            check("rand_dready", dllp_ready, exp_dr);
            if (exp_tr && tlp_valid)  void'(tq.pop_front());
            if (exp_dr && dllp_valid) void'(dq.pop_front());
            exp_prev = emit;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
